sha1_msg_pad: RTL and testbench

Upstream message stage of the UART-to-SHA-1 path. It takes the received byte stream from the UART receiver, packs it big-endian into 512-bit SHA-1 blocks, and appends the standard padding: 0x80, zero fill and a 64-bit bit-length. It presents each block to the SHA-1 compression core with a valid/ready handshake. First/last flags tell the core when to reload H0..H4 and when to emit the 160-bit digest.

---
 rtl/sha1_msg_pad.sv | 154 +++++++++++++++
 tb/tb_sha1_msg_pad.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_pad.sv
// SHA-1 message padder: packs a byte stream big-endian into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands each block to
// the compression core over a valid/ready handshake with first/last flags.
`timescale 1ns/1ps
module sha1_msg_pad #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [7:0]   din,
  input  logic         din_vld,
  input  logic         din_last,
  output logic         din_rdy,
  output logic [511:0] blk,
  output logic         blk_vld,
  input  logic         blk_rdy,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {StFill, StPad, StOut, StExtra} state_e;

  state_e                 state_q, state_d;
  logic [63:0][7:0]       blk_q, blk_d;     // element 63 is message byte 0
  logic [5:0]             idx_q, idx_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   pend_pad_q, pend_pad_d;
  logic                   pend_len_q, pend_len_d;
  logic                   msg_start_q, msg_start_d;  // next block opens a message
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   din_rdy_q, din_rdy_d;
  logic                   blk_vld_q, blk_vld_d;

  logic                   accept;
  logic                   xfer;
  logic [63:0]            bit_len;

  assign accept  = din_vld & din_rdy_q;
  assign xfer    = blk_vld_q & blk_rdy;
  assign bit_len = {{(61 - LEN_W){1'b0}}, len_q, 3'b000};

  assign din_rdy   = din_rdy_q;
  assign blk_vld   = blk_vld_q;
  assign blk       = blk_q;
  assign blk_first = first_q;
  assign blk_last  = last_q;

  // State and datapath registers; all state is discarded on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StFill;
      blk_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      pend_pad_q  <= 1'b0;
      pend_len_q  <= 1'b0;
      msg_start_q <= 1'b1;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      din_rdy_q   <= 1'b0;
      blk_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pend_pad_q  <= pend_pad_d;
      pend_len_q  <= pend_len_d;
      msg_start_q <= msg_start_d;
      first_q     <= first_d;
      last_q      <= last_d;
      din_rdy_q   <= din_rdy_d;
      blk_vld_q   <= blk_vld_d;
    end
  end

  // Next-state logic, block assembly and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pend_pad_d  = pend_pad_q;
    pend_len_d  = pend_len_q;
    msg_start_d = msg_start_q;
    first_d     = first_q;
    last_d      = last_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          blk_d[6'd63 - idx_q] = din;
          idx_d                = idx_q + 6'd1;
          len_d                = len_q + LEN_W'(1);
          if (idx_q == 6'd63) begin
            // Full block; a trailing din_last defers 0x80 to an extra block.
            state_d    = StOut;
            first_d    = msg_start_q;
            last_d     = 1'b0;
            pend_pad_d = din_last;
          end else if (din_last) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        // idx_q holds n, the count of data bytes in this block.
        for (int unsigned i = 0; i < 64; i++) begin
          if (6'(i) == idx_q) begin
            blk_d[6'(63 - i)] = 8'h80;
          end else if (6'(i) > idx_q) begin
            blk_d[6'(63 - i)] = 8'h00;
          end
        end
        if (idx_q <= 6'd55) begin
          blk_d[7:0] = bit_len;
          last_d     = 1'b1;
        end else begin
          last_d     = 1'b0;
          pend_len_d = 1'b1;
        end
        first_d = msg_start_q;
        idx_d   = '0;
        state_d = StOut;
      end
      StOut: begin
        if (xfer) begin
          state_d     = (pend_pad_q || pend_len_q) ? StExtra : StFill;
          idx_d       = '0;
          msg_start_d = last_q;
          if (last_q) begin
            len_d = '0;
          end
        end
      end
      StExtra: begin
        blk_d      = '0;
        blk_d[63]  = pend_pad_q ? 8'h80 : 8'h00;
        blk_d[7:0] = bit_len;
        first_d    = 1'b0;
        last_d     = 1'b1;
        pend_pad_d = 1'b0;
        pend_len_d = 1'b0;
        state_d    = StOut;
      end
      default: state_d = StFill;
    endcase

    din_rdy_d = (state_d == StFill);
    blk_vld_d = (state_d == StOut);
  end

endmodule

// File: tb/tb_sha1_msg_pad.sv
// Self-checking bench for sha1_msg_pad: a queue-based padding model predicts
// every block; directed vectors, timing sequences and random traffic.
`timescale 1ns/1ps
module tb_sha1_msg_pad;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   din = 8'h00;
  logic         din_vld = 1'b0;
  logic         din_last = 1'b0;
  logic         din_rdy;
  logic [511:0] blk;
  logic         blk_vld;
  logic         blk_rdy = 1'b0;
  logic         blk_first;
  logic         blk_last;

  sha1_msg_pad #(.LEN_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din       (din),
    .din_vld   (din_vld),
    .din_last  (din_last),
    .din_rdy   (din_rdy),
    .blk       (blk),
    .blk_vld   (blk_vld),
    .blk_rdy   (blk_rdy),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    bit           first;
    bit           last;
  } blk_t;

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic [7:0]  step;
    int          exp_nblk;
    logic [31:0] exp_top;
    logic [63:0] exp_len;
  } vec_t;

  blk_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled
  int           mon_count = 0;
  logic [511:0] mon_last = '0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: append 0x80, zero fill to 56 mod 64, 64-bit bit length, cut into blocks.
  task automatic push_model(input logic [7:0] m[$]);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] d;
    int           nb;
    blk_t         b;
    p = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) d[511 - 8*j -: 8] = p[64*k + j];
      b.data  = d;
      b.first = (k == 0);
      b.last  = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       blk_rdy = 1'b1;
      1:       blk_rdy = 1'($urandom_range(0, 1));
      default: blk_rdy = 1'b0;
    endcase
  end

  // Transfer monitor: inputs settle after the rising edge, so vld&rdy here means a transfer.
  always @(negedge clk) begin
    blk_t e;
    if (rstn && blk_vld && blk_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", 512'(1), 512'(0));
      end else begin
        e = exp_q.pop_front();
        check("blk_data", blk, e.data);
        check("blk_first", 512'(blk_first), 512'(e.first));
        check("blk_last", 512'(blk_last), 512'(e.last));
      end
      mon_count++;
      mon_last = blk;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
    int waited = 0;
    din_vld = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    din = b;
    din_last = last;
    din_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (din_rdy) break;
      waited++;
      if (waited > 2000) begin
        check("send_timeout", 512'(1), 512'(0));
        break;
      end
    end
    @(posedge clk); #1;
    din_vld = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int max_gap);
    for (int i = 0; i < m.size(); i++)
      send_byte(m[i], i == m.size() - 1, $urandom_range(0, max_gap));
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {blk_vld, din_rdy, blk_first, blk_last, blk}, '0);
  endtask

  vec_t         vecs[4];
  logic [7:0]   m[$];
  logic [511:0] abc_blk;

  initial begin
    vecs[0] = '{n: 3,  base: 8'h61, step: 8'h01, exp_nblk: 1, exp_top: 32'h61626380,
                exp_len: 64'h18};
    vecs[1] = '{n: 55, base: 8'h00, step: 8'h01, exp_nblk: 1, exp_top: 32'h00010203,
                exp_len: 64'h1B8};
    vecs[2] = '{n: 56, base: 8'h00, step: 8'h01, exp_nblk: 2, exp_top: 32'h00000000,
                exp_len: 64'h1C0};
    vecs[3] = '{n: 64, base: 8'hAA, step: 8'h00, exp_nblk: 2, exp_top: 32'h80000000,
                exp_len: 64'h200};
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[63:0] = 64'h18;

    // Reset values, and din_rdy only after the first edge out of reset.
    #23;
    check_reset_outputs("reset_values");
    @(posedge clk); #1;
    rstn = 1'b1;
    check("rdy_before_edge", 512'(din_rdy), 512'(0));
    @(posedge clk); #1;
    check("rdy_after_edge", 512'(din_rdy), 512'(1));

    // Directed vectors from a table.
    rdy_mode = 0;
    for (int v = 0; v < 4; v++) begin
      m = {};
      for (int i = 0; i < vecs[v].n; i++) m.push_back(vecs[v].base + 8'(i) * vecs[v].step);
      push_model(m);
      mon_count = 0;
      send_msg(m, 0);
      drain();
      check($sformatf("vec%0d_nblk", v), 512'(mon_count), 512'(vecs[v].exp_nblk));
      check($sformatf("vec%0d_top", v), 512'(mon_last[511:480]), 512'(vecs[v].exp_top));
      check($sformatf("vec%0d_len", v), 512'(mon_last[63:0]), 512'(vecs[v].exp_len));
    end

    // "abc": PAD cycle after last accept, blk_vld one cycle later.
    m = {8'h61, 8'h62, 8'h63};
    push_model(m);
    send_msg(m, 0);
    check("abc_pad_cycle", 512'({blk_vld, din_rdy}), 512'(2'b00));
    @(posedge clk); #1;
    check("abc_vld_cycle", 512'({blk_vld, din_rdy}), 512'(2'b10));
    drain();

    // 64 bytes: blk_vld right after the 64th accept, then "abc" opens a new message.
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'hAA);
    push_model(m);
    send_msg(m, 0);
    check("full_vld_cycle", 512'({blk_vld, din_rdy}), 512'(2'b10));
    drain();
    m = {8'h61, 8'h62, 8'h63};
    push_model(m);
    send_msg(m, 0);
    drain();
    check("abc_after_full", mon_last, abc_blk);

    // Backpressure: stalled block stays put and ignores offered bytes.
    rdy_mode = 2;
    @(posedge clk); #1;
    m = {};
    for (int i = 0; i < 67; i++) m.push_back(8'(i));
    push_model(m);
    for (int i = 0; i < 64; i++) send_byte(m[i], 1'b0, 0);
    din = 8'h55;
    din_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_blk", blk, exp_q[0].data);
      check("stall_flags", 512'({blk_vld, din_rdy, blk_first, blk_last}),
            512'({1'b1, 1'b0, exp_q[0].first, exp_q[0].last}));
    end
    @(posedge clk); #1;
    din_vld = 1'b0;
    rdy_mode = 0;
    for (int i = 64; i < 67; i++) send_byte(m[i], i == 66, 0);
    drain();

    // Reset mid-message discards everything.
    for (int i = 0; i < 20; i++) send_byte(8'(i + 3), 1'b0, 0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_msg");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    m = {8'h61, 8'h62, 8'h63};
    push_model(m);
    mon_count = 0;
    send_msg(m, 0);
    drain();
    check("abc_after_reset", mon_last, abc_blk);
    check("abc_after_reset_n", 512'(mon_count), 512'(1));

    // Random messages, gaps and backpressure against the model.
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      m = {};
      for (int i = 0; i < int'($urandom_range(1, 140)); i++) m.push_back(8'($urandom));
      push_model(m);
      send_msg(m, 2);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
